// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART on the CPU data bus (0x40000018-0x40000023).
// Registers: TXD (0x18), RXD (0x1C), CON (0x20). Read data is combinational.
// The receiver oversamples 16x. There is a one-byte holding register in each direction.
// Optional feature: define UART_IRQ_EN to add the irq port and the CON[0] irq_en bit.
module uart_mmio #(
    parameter int BAUD_DIV16 = 326
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
`ifdef UART_IRQ_EN
    output logic        irq,
`endif
    output logic        tx
);

    localparam int DIV_W = (BAUD_DIV16 > 1) ? $clog2(BAUD_DIV16) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV16 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    logic             sel_txd, sel_rxd, sel_con;
    logic             rxd_read, con_write;
    logic             unused_wdata;

    tx_state_t        tx_state;
    logic             tx_busy;
    logic [7:0]       tx_data;
    logic [7:0]       tx_shift;
    logic [2:0]       tx_bit;
    logic [3:0]       tx_sub;
    logic [DIV_W-1:0] tx_div;
    logic             tx_tick, tx_done, tx_accept;

    logic             rx_meta, rx_sync;
    rx_state_t        rx_state;
    logic [DIV_W-1:0] rx_div;
    logic             rx_tick;
    logic [3:0]       rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_data;
    logic             rx_valid, overrun, frame_err;
    logic             irq_en;

    assign sel_txd      = (addr == 32'h4000_0018);
    assign sel_rxd      = (addr == 32'h4000_001C);
    assign sel_con      = (addr == 32'h4000_0020);
    assign rxd_read     = rd && sel_rxd;
    assign con_write    = wr && sel_con;
    assign unused_wdata = ^wdata[31:8];

    // A write during the last cycle of the stop bit is accepted, so frames can run back-to-back with no idle gap.
    assign tx_tick   = (tx_div == DIV_LAST);
    assign tx_done   = (tx_state == TX_STOP) && tx_tick && (tx_sub == 4'd15);
    assign tx_accept = wr && sel_txd && (!tx_busy || tx_done);

    // Transmit FSM: restarts its own divider on every accepted byte and holds each bit for 16 ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_data  <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_sub   <= '0;
            tx_div   <= '0;
        end else if (tx_accept) begin
            tx_state <= TX_START;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_data  <= wdata[7:0];
            tx_shift <= wdata[7:0];
            tx_bit   <= '0;
            tx_sub   <= '0;
            tx_div   <= '0;
        end else if (tx_state != TX_IDLE) begin
            tx_div <= tx_tick ? '0 : tx_div + 1'b1;
            if (tx_tick) begin
                tx_sub <= tx_sub + 1'b1;
                if (tx_sub == 4'd15) begin
                    case (tx_state)
                        TX_START: begin
                            tx_state <= TX_DATA;
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= '0;
                        end
                        TX_DATA: begin
                            if (tx_bit == 3'd7) begin
                                tx_state <= TX_STOP;
                                tx       <= 1'b1;
                            end else begin
                                tx_bit   <= tx_bit + 1'b1;
                                tx       <= tx_shift[0];
                                tx_shift <= {1'b0, tx_shift[7:1]};
                            end
                        end
                        TX_STOP: begin
                            tx_state <= TX_IDLE;
                            tx_busy  <= 1'b0;
                        end
                        default: tx_state <= TX_IDLE;
                    endcase
                end
            end
        end
    end

    // Two-flop synchroniser for the asynchronous serial input; it powers up at the idle line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_tick = (rx_div == DIV_LAST);

    // Receive FSM with flags: free-running 16x divider, mid-bit sampling, and overrun/framing detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state  <= RX_IDLE;
            rx_div    <= '0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_div <= rx_tick ? '0 : rx_div + 1'b1;
            if (rxd_read) rx_valid <= 1'b0;
            if (con_write && wdata[4]) overrun <= 1'b0;
            if (con_write && wdata[5]) frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_tick && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_cnt == 4'd7) begin
                            rx_cnt   <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == 4'd15) begin
                            rx_shift <= {rx_sync, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 1'b1;
                            if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == 4'd15) begin
                            if (rx_sync) begin
                                rx_data  <= rx_shift;
                                rx_valid <= 1'b1;
                                if (rx_valid && !rxd_read) overrun <= 1'b1;
                                rx_state <= RX_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                rx_state  <= RX_BREAK;
                            end
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_sync) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_IRQ_EN
    // Interrupt enable bit, written through CON[0].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_en <= 1'b0;
        else if (con_write) irq_en <= wdata[0];
    end

    assign irq = irq_en & rx_valid;
`else
    assign irq_en = 1'b0;
`endif

    // Combinational read mux: zero unless a mapped register is being read.
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd)      rdata = {24'b0, tx_data};
            else if (sel_rxd) rdata = {24'b0, rx_data};
            else if (sel_con) rdata = {26'b0, frame_err, overrun, tx_busy, rx_valid, 1'b0, irq_en};
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed bench for uart_mmio with BAUD_DIV16=4, so one bit time is 64 clocks.
module tb_uart_mmio;

    localparam int          DIV      = 4;
    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    logic        clk, reset, rd, wr, rx, tx;
    logic [31:0] addr, wdata, rdata;
`ifdef UART_IRQ_EN
    logic        irq;
`endif

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] rdata_s;
    logic        tx_s;
    int          busy_cycles;
    logic [9:0]  frame_a5;
    logic [9:0]  frame_5a;

    uart_mmio #(.BAUD_DIV16(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .rx    (rx),
`ifdef UART_IRQ_EN
        .irq   (irq),
`endif
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One bus cycle: drive at the falling edge, sample rdata/tx mid-cycle, then release after the rising edge.
    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
        #1;
        rdata_s = rdata;
        tx_s    = tx;
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    // Drives one serial frame (start, 8 data bits LSB first, given stop level) and then idles the line.
    task automatic sendSerial(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = frame[i];
            repeat (63) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        rx    = 1'b1;
        // Expected serial waveforms, bit 0 is the start bit: 0xA5 -> 0,1,0,1,0,0,1,0,1,1 and 0x5A -> 0,0,1,0,1,1,0,1,0,1.
        frame_a5 = 10'b11_0100_1010;
        frame_5a = 10'b10_1011_0100;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_tx", {31'b0, tx}, 32'd1);
        checkOutput("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("con_after_reset", rdata_s, 32'd0);

        // Reset asserted in the middle of a transmission
        applyStimulus(1'b0, 1'b1, ADDR_TXD, 32'hA5);
        repeat (10) @(negedge clk);
        #1;
        checkOutput("tx_mid_frame", {31'b0, tx}, 32'd0);
        addr  = ADDR_CON;
        reset = 1'b0;
        #1;
        checkOutput("tx_reset_mid_frame", {31'b0, tx}, 32'd1);
        checkOutput("rdata_no_rd", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("con_after_release", rdata_s, 32'd0);
        applyStimulus(1'b1, 1'b0, ADDR_TXD, 32'd0);
        checkOutput("txd_after_release", rdata_s, 32'd0);

        // Full 0xA5 frame: bit levels at mid-bit and busy duration
        applyStimulus(1'b0, 1'b1, ADDR_TXD, 32'hA5);
        busy_cycles = 0;
        for (int c = 0; c < 700; c++) begin
            applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
            if (rdata_s[3]) busy_cycles++;
            if (c < 640 && (c % 64) == 32)
                checkOutput($sformatf("tx_a5_bit%0d", c / 64), {31'b0, tx_s}, {31'b0, frame_a5[c / 64]});
        end
        checkOutput("tx_busy_cycles", busy_cycles, 32'd640);
        checkOutput("tx_idle_after_a5", {31'b0, tx_s}, 32'd1);
        applyStimulus(1'b1, 1'b0, ADDR_TXD, 32'd0);
        checkOutput("txd_last_accepted", rdata_s, 32'hA5);

        // Unmapped and misaligned addresses
        applyStimulus(1'b1, 1'b0, 32'h4000_0019, 32'd0);
        checkOutput("read_misaligned", rdata_s, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h5000_0018, 32'd0);
        checkOutput("read_unmapped", rdata_s, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h4000_0019, 32'hFF);
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("write_misaligned_ignored", rdata_s, 32'd0);

        // Write while busy is dropped; a write in the final stop-bit cycle follows with no gap
        applyStimulus(1'b0, 1'b1, ADDR_TXD, 32'h0F);
        for (int c = 0; c < 1340; c++) begin
            if (c == 100) begin
                applyStimulus(1'b0, 1'b1, ADDR_TXD, 32'h3C);
            end else if (c == 101) begin
                applyStimulus(1'b1, 1'b0, ADDR_TXD, 32'd0);
                checkOutput("txd_busy_write_ignored", rdata_s, 32'h0F);
            end else if (c == 639) begin
                applyStimulus(1'b0, 1'b1, ADDR_TXD, 32'h5A);
            end else begin
                applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
            end
            if (c == 608) checkOutput("tx_first_stop", {31'b0, tx_s}, 32'd1);
            if (c == 640) begin
                checkOutput("tx_b2b_no_gap", {31'b0, tx_s}, 32'd0);
                checkOutput("tx_b2b_busy", {31'b0, rdata_s[3]}, 32'd1);
            end
            if (c >= 640 && c < 1280 && ((c - 640) % 64) == 32)
                checkOutput($sformatf("tx_5a_bit%0d", (c - 640) / 64), {31'b0, tx_s}, {31'b0, frame_5a[(c - 640) / 64]});
            if (c == 1330) checkOutput("tx_idle_after_5a", {31'b0, tx_s}, 32'd1);
        end
        applyStimulus(1'b1, 1'b0, ADDR_TXD, 32'd0);
        checkOutput("txd_b2b_value", rdata_s, 32'h5A);

        // Single byte reception
        sendSerial(8'h5A, 1'b1);
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("rx_con_valid", rdata_s, 32'h04);
        applyStimulus(1'b1, 1'b0, ADDR_RXD, 32'd0);
        checkOutput("rx_data_5a", rdata_s, 32'h5A);
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("rx_con_cleared", rdata_s, 32'h00);

        // Overrun: second byte overwrites the unread first
        sendSerial(8'h11, 1'b1);
        sendSerial(8'h22, 1'b1);
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("rx_con_overrun", rdata_s, 32'h14);
        applyStimulus(1'b1, 1'b0, ADDR_RXD, 32'd0);
        checkOutput("rx_data_second", rdata_s, 32'h22);
        applyStimulus(1'b0, 1'b1, ADDR_CON, 32'h10);
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("rx_overrun_cleared", rdata_s, 32'h00);

        // Short low glitch is rejected
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("rx_glitch_rejected", rdata_s, 32'h00);

        // Stop bit low gives a framing error and no data
        sendSerial(8'h33, 1'b0);
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("rx_frame_err", rdata_s, 32'h20);
        applyStimulus(1'b0, 1'b1, ADDR_CON, 32'h20);
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("rx_frame_err_cleared", rdata_s, 32'h00);

`ifdef UART_IRQ_EN
        // Interrupt follows irq_en & rx_valid
        applyStimulus(1'b0, 1'b1, ADDR_CON, 32'h01);
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("con_irq_en", rdata_s, 32'h01);
        sendSerial(8'h77, 1'b1);
        #1;
        checkOutput("irq_set", {31'b0, irq}, 32'd1);
        applyStimulus(1'b1, 1'b0, ADDR_RXD, 32'd0);
        checkOutput("irq_rx_data", rdata_s, 32'h77);
        checkOutput("irq_cleared", {31'b0, irq}, 32'd0);
`else
        // Without the interrupt option CON[0] is not writable
        applyStimulus(1'b0, 1'b1, ADDR_CON, 32'h01);
        applyStimulus(1'b1, 1'b0, ADDR_CON, 32'd0);
        checkOutput("con_bit0_ignored", rdata_s, 32'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
